// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: Moore FSM with run/step/halt
// gating of all write strobes, plus cycle and retired-instruction counters.
module cpu_mc_ctrl (
  input  logic [5:0]  SW,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [2:1]  ALUSrcB,
  output logic [2:1]  PCSource,
  output logic [3:1]  ALUCtrl,
  output logic [4:1]  State,
  output logic        Illegal,
  output logic [32:1] Cycle_Count,
  output logic [32:1] Instr_Count
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  logic clk, rst, step_mode, step_in, halt;
  logic unused_sw5;

  assign clk        = SW[0];
  assign rst        = SW[1];
  assign step_mode  = SW[2];
  assign step_in    = SW[3];
  assign halt       = SW[4];
  assign unused_sw5 = SW[5];

  state_e      state_q, state_d;
  logic        step_q;
  logic        illegal_q, illegal_d;
  logic [31:0] cycle_q, instr_q;
  logic        retire;
  logic        step_edge, adv;
  logic        funct_ok;
  logic [2:0]  funct_alu;
  logic        pc_write_s, mem_write_s, ir_write_s, reg_write_s;

  // Halt is only honoured at an instruction boundary so a started instruction always completes.
  assign step_edge = step_in & ~step_q;
  assign adv       = (~step_mode | step_edge) & ~rst & ~((state_q == StFetch) & halt);

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = AluAdd;
    case (Funct)
      6'h20:   funct_alu = AluAdd;
      6'h22:   funct_alu = AluSub;
      6'h24:   funct_alu = AluAnd;
      6'h25:   funct_alu = AluOr;
      6'h2A:   funct_alu = AluSlt;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Moore outputs; selects follow the state even while stalled, strobes are gated below.
  always_comb begin
    pc_write_s  = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUCtrl     = AluAdd;
    unique case (state_q)
      StFetch: begin
        MemRead    = 1'b1;
        ir_write_s = 1'b1;
        ALUSrcB    = 2'b01;
        pc_write_s = 1'b1;
      end
      StDecode: ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        reg_write_s = 1'b1;
        MemtoReg    = 1'b1;
      end
      StMemWr: begin
        mem_write_s = 1'b1;
        IorD        = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUCtrl = funct_alu;
      end
      StAluWb: begin
        RegDst      = 1'b1;
        reg_write_s = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        ALUCtrl    = AluSub;
        PCSource   = 2'b01;
        pc_write_s = Zero;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: reg_write_s = 1'b1;
      StJump: begin
        pc_write_s = 1'b1;
        PCSource   = 2'b10;
      end
      default: ;
    endcase
  end

  assign PCWrite  = pc_write_s & adv;
  assign MemWrite = mem_write_s & adv;
  assign IRWrite  = ir_write_s & adv;
  assign RegWrite = reg_write_s & adv;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    if (adv) begin
      unique case (state_q)
        StFetch: state_d = StDecode;
        StDecode: begin
          case (Op)
            OpLw, OpSw: state_d = StMemAdr;
            OpRtype:    state_d = StExec;
            OpBeq:      state_d = StBranch;
            OpAddi:     state_d = StAddiEx;
            OpJ:        state_d = StJump;
            default: begin
              state_d   = StFetch;
              illegal_d = 1'b1;
            end
          endcase
        end
        StMemAdr: state_d = (Op == OpSw) ? StMemWr : StMemRd;
        StMemRd:  state_d = StMemWb;
        StExec: begin
          if (funct_ok) begin
            state_d = StAluWb;
          end else begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        end
        StAddiEx: state_d = StAddiWb;
        StMemWb, StMemWr, StAluWb, StBranch, StAddiWb, StJump: begin
          state_d = StFetch;
          retire  = 1'b1;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      step_q    <= 1'b0;
      illegal_q <= 1'b0;
      cycle_q   <= 32'd0;
      instr_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_in;
      illegal_q <= illegal_d;
      if (adv) begin
        cycle_q <= cycle_q + 32'd1;
      end
      if (retire) begin
        instr_q <= instr_q + 32'd1;
      end
    end
  end

  assign State       = state_q;
  assign Illegal     = illegal_q;
  assign Cycle_Count = cycle_q;
  assign Instr_Count = instr_q;

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Bench for cpu_mc_ctrl: table of instructions with expected state walks, scoreboarded
// per-cycle output checks, and hand sequences for step, halt and mid-instruction reset.
module tb_cpu_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        halt = 1'b0;
  logic [5:0]  op = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        zero = 1'b0;
  logic [5:0]  sw;

  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUCtrl;
  logic [3:0]  State;
  logic        Illegal;
  logic [31:0] Cycle_Count, Instr_Count;

  assign sw = {1'b0, halt, step, step_mode, rst, clk};

  cpu_mc_ctrl dut (
    .SW          (sw),
    .Op          (op),
    .Funct       (funct),
    .Zero        (zero),
    .PCWrite     (PCWrite),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUCtrl     (ALUCtrl),
    .State       (State),
    .Illegal     (Illegal),
    .Cycle_Count (Cycle_Count),
    .Instr_Count (Instr_Count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
  } outs_t;

  typedef struct packed {
    outs_t      o;
    logic       alu_care;
    logic [2:0] alu;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          n;
    logic [19:0] seq;
    logic        retire;
    logic        bad;
  } vec_t;

  outs_t act;
  assign act = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource};

  int   vectors = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Expected controls for one state, written from the state table.
  function automatic exp_t model(input logic [3:0] st, input logic [5:0] fn, input logic z,
                                 input logic adv);
    exp_t e;
    e = '0;
    e.o.state = st;
    e.alu = 3'b010;
    case (st)
      4'd0: begin
        e.o.mem_read = 1'b1; e.o.ir_write = adv; e.o.alu_src_b = 2'b01;
        e.o.pc_write = adv; e.alu_care = 1'b1;
      end
      4'd1: begin e.o.alu_src_b = 2'b11; e.alu_care = 1'b1; end
      4'd2: begin e.o.alu_src_a = 1'b1; e.o.alu_src_b = 2'b10; e.alu_care = 1'b1; end
      4'd3: begin e.o.mem_read = 1'b1; e.o.iord = 1'b1; end
      4'd4: begin e.o.reg_write = adv; e.o.mem_to_reg = 1'b1; end
      4'd5: begin e.o.mem_write = adv; e.o.iord = 1'b1; end
      4'd6: begin
        e.o.alu_src_a = 1'b1;
        e.alu_care = 1'b1;
        case (fn)
          6'h20:   e.alu = 3'b010;
          6'h22:   e.alu = 3'b110;
          6'h24:   e.alu = 3'b000;
          6'h25:   e.alu = 3'b001;
          6'h2A:   e.alu = 3'b111;
          default: e.alu_care = 1'b0;
        endcase
      end
      4'd7: begin e.o.reg_dst = 1'b1; e.o.reg_write = adv; end
      4'd8: begin
        e.o.alu_src_a = 1'b1; e.o.pc_source = 2'b01; e.o.pc_write = z & adv;
        e.alu = 3'b110; e.alu_care = 1'b1;
      end
      4'd9: begin e.o.alu_src_a = 1'b1; e.o.alu_src_b = 2'b10; e.alu_care = 1'b1; end
      4'd10: e.o.reg_write = adv;
      4'd11: begin e.o.pc_write = adv; e.o.pc_source = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  // Push the expectation as the cycle is driven; pop and compare mid-cycle.
  task automatic cycle_check(input string name, input logic [3:0] st, input logic adv);
    exp_t e;
    sb.push_back(model(st, funct, zero, adv));
    @(negedge clk);
    e = sb.pop_front();
    check(name, 64'(act), 64'(e.o));
    if (e.alu_care) check({name, "/alu"}, 64'(ALUCtrl), 64'(e.alu));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_mode = 1'b0; step = 1'b0; halt = 1'b0;
    @(posedge clk);
    #1;
    cycle_check("reset", 4'd0, 1'b0);
    rst = 1'b0;
    check("reset/cycles", 64'(Cycle_Count), 64'd0);
    check("reset/instrs", 64'(Instr_Count), 64'd0);
    check("reset/illegal", 64'(Illegal), 64'd0);
  endtask

  task automatic add_vec(input string name, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input int n, input logic [19:0] seq,
                         input logic ret, input logic bad);
    vec_t v;
    v.name = name; v.op = o; v.funct = f; v.zero = z; v.n = n;
    v.seq = seq; v.retire = ret; v.bad = bad;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_cyc;
    logic [31:0] exp_ins;
    logic        exp_ill;

    // State walks are packed one nibble per cycle, first state in the low nibble.
    add_vec("lw",        6'h23, 6'h00, 1'b0, 5, 20'h43210, 1'b1, 1'b0);
    add_vec("add",       6'h00, 6'h20, 1'b0, 4, 20'h07610, 1'b1, 1'b0);
    add_vec("sub",       6'h00, 6'h22, 1'b0, 4, 20'h07610, 1'b1, 1'b0);
    add_vec("and",       6'h00, 6'h24, 1'b0, 4, 20'h07610, 1'b1, 1'b0);
    add_vec("or",        6'h00, 6'h25, 1'b0, 4, 20'h07610, 1'b1, 1'b0);
    add_vec("slt",       6'h00, 6'h2A, 1'b0, 4, 20'h07610, 1'b1, 1'b0);
    add_vec("beq_taken", 6'h04, 6'h00, 1'b1, 3, 20'h00810, 1'b1, 1'b0);
    add_vec("beq_not",   6'h04, 6'h00, 1'b0, 3, 20'h00810, 1'b1, 1'b0);
    add_vec("sw",        6'h2B, 6'h00, 1'b0, 4, 20'h05210, 1'b1, 1'b0);
    add_vec("addi",      6'h08, 6'h00, 1'b0, 4, 20'h0A910, 1'b1, 1'b0);
    add_vec("j",         6'h02, 6'h00, 1'b0, 3, 20'h00B10, 1'b1, 1'b0);
    add_vec("bad_op",    6'h3F, 6'h00, 1'b0, 2, 20'h00010, 1'b0, 1'b1);
    add_vec("bad_funct", 6'h00, 6'h3F, 1'b0, 3, 20'h00610, 1'b0, 1'b1);
    add_vec("lw_again",  6'h23, 6'h00, 1'b0, 5, 20'h43210, 1'b1, 1'b0);

    do_reset();
    exp_cyc = 0; exp_ins = 0; exp_ill = 1'b0;
    foreach (vecs[k]) begin
      op = vecs[k].op; funct = vecs[k].funct; zero = vecs[k].zero;
      for (int i = 0; i < vecs[k].n; i++) begin
        cycle_check(vecs[k].name, vecs[k].seq[i*4 +: 4], 1'b1);
      end
      exp_cyc += 32'(vecs[k].n);
      exp_ins += 32'(vecs[k].retire);
      exp_ill |= vecs[k].bad;
      check({vecs[k].name, "/cycles"}, 64'(Cycle_Count), 64'(exp_cyc));
      check({vecs[k].name, "/instrs"}, 64'(Instr_Count), 64'(exp_ins));
      check({vecs[k].name, "/illegal"}, 64'(Illegal), 64'(exp_ill));
    end

    // Reset landing in MEMRD of a lw: no register write, FETCH next, sticky flag cleared.
    op = 6'h23; funct = 6'h00; zero = 1'b0;
    cycle_check("rst_mid/f", 4'd0, 1'b1);
    cycle_check("rst_mid/d", 4'd1, 1'b1);
    cycle_check("rst_mid/a", 4'd2, 1'b1);
    rst = 1'b1;
    cycle_check("rst_mid/memrd", 4'd3, 1'b0);
    rst = 1'b0;
    check("rst_mid/state", 64'(State), 64'd0);
    check("rst_mid/cycles", 64'(Cycle_Count), 64'd0);
    check("rst_mid/instrs", 64'(Instr_Count), 64'd0);
    check("rst_mid/illegal", 64'(Illegal), 64'd0);

    // Step mode: a long step pulse advances exactly once.
    do_reset();
    step_mode = 1'b1;
    cycle_check("step/idle", 4'd0, 1'b0);
    cycle_check("step/idle", 4'd0, 1'b0);
    step = 1'b1;
    cycle_check("step/edge", 4'd0, 1'b1);
    for (int i = 0; i < 9; i++) cycle_check("step/held", 4'd1, 1'b0);
    check("step/cycles", 64'(Cycle_Count), 64'd1);
    check("step/instrs", 64'(Instr_Count), 64'd0);
    step = 1'b0;
    step_mode = 1'b0;

    // Halt in FETCH freezes everything; release fetches on the next edge.
    do_reset();
    halt = 1'b1;
    for (int i = 0; i < 5; i++) cycle_check("halt/hold", 4'd0, 1'b0);
    check("halt/cycles", 64'(Cycle_Count), 64'd0);
    halt = 1'b0;
    cycle_check("halt/release", 4'd0, 1'b1);
    check("halt/state", 64'(State), 64'd1);
    check("halt/cycles_after", 64'(Cycle_Count), 64'd1);

    // Halt beats a step pulse in FETCH; the consumed edge does not replay after release.
    do_reset();
    step_mode = 1'b1; halt = 1'b1; step = 1'b1;
    cycle_check("halt_step/a", 4'd0, 1'b0);
    cycle_check("halt_step/b", 4'd0, 1'b0);
    halt = 1'b0;
    cycle_check("halt_step/c", 4'd0, 1'b0);
    check("halt_step/cycles", 64'(Cycle_Count), 64'd0);
    step = 1'b0; step_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
